// File: rtl/mfsk_modulator.sv
// M-ary FSK square-wave modulator: serialises valid/ready words into BITS_PER_SYM-bit
// symbols and sends each as one of 2^BITS_PER_SYM phase-continuous tones for SYM_CYCLES cycles.
module mfsk_modulator #(
  parameter int DATA_W       = 8,
  parameter int BITS_PER_SYM = 2,
  parameter int SYM_CYCLES   = 400,
  parameter int BASE_LIMIT   = 99,
  parameter int STEP_LIMIT   = 25,
  parameter int CNT_W        = 10,
  parameter int MSB_FIRST    = 1,
  parameter int IDLE_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  output logic                    fsk_out,
  output logic [BITS_PER_SYM-1:0] sym_idx,
  output logic                    sym_start,
  output logic                    busy
);

  localparam int BPS_SAFE = (BITS_PER_SYM > 0) ? BITS_PER_SYM : 1;
  localparam int M        = 2 ** BPS_SAFE;
  localparam int NSYM     = DATA_W / BPS_SAFE;
  localparam int SC_W     = (SYM_CYCLES > 2) ? $clog2(SYM_CYCLES) : 1;
  localparam int SL_W     = $clog2(NSYM + 1);

  generate
    if (BITS_PER_SYM < 1 || (DATA_W % BPS_SAFE) != 0) begin : g_bad_width
      $error("mfsk_modulator: DATA_W must be a non-zero multiple of BITS_PER_SYM");
    end
    if (SYM_CYCLES < 2) begin : g_bad_sym
      $error("mfsk_modulator: SYM_CYCLES must be at least 2");
    end
    if (BASE_LIMIT - (M - 1) * STEP_LIMIT < 1) begin : g_bad_limit
      $error("mfsk_modulator: highest tone limit must be at least 1");
    end
    if (BASE_LIMIT >= 2 ** CNT_W) begin : g_bad_cnt
      $error("mfsk_modulator: BASE_LIMIT does not fit in CNT_W bits");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [SC_W-1:0]         sym_cnt;
  logic [SL_W-1:0]         sym_left;
  logic [DATA_W-1:0]       shreg;
  logic [CNT_W-1:0]        tone_cnt;
  logic [CNT_W-1:0]        limit_tab [M];
  logic [BITS_PER_SYM-1:0] load_sym, next_sym;
  logic [DATA_W-1:0]       load_rest, next_rest;
  logic                    last_cycle, sym_wrap, load, tone_active;

  // Per-tone half-period limits are fixed constants; only a mux remains at runtime.
  for (genvar k = 0; k < M; k++) begin : g_lim
    assign limit_tab[k] = CNT_W'(BASE_LIMIT - k * STEP_LIMIT);
  end

  if (MSB_FIRST != 0) begin : g_msb
    assign load_sym  = s_data[DATA_W-1 -: BITS_PER_SYM];
    assign load_rest = s_data << BITS_PER_SYM;
    assign next_sym  = shreg[DATA_W-1 -: BITS_PER_SYM];
    assign next_rest = shreg << BITS_PER_SYM;
  end else begin : g_lsb
    assign load_sym  = s_data[BITS_PER_SYM-1:0];
    assign load_rest = s_data >> BITS_PER_SYM;
    assign next_sym  = shreg[BITS_PER_SYM-1:0];
    assign next_rest = shreg >> BITS_PER_SYM;
  end

  assign sym_wrap    = (sym_cnt == SC_W'(SYM_CYCLES - 1));
  assign last_cycle  = sym_wrap && (sym_left == SL_W'(1));
  assign tone_active = (state_q == SEND) || (IDLE_MODE != 0);

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    busy      = 1'b0;
    sym_start = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        busy      = 1'b1;
        sym_start = (sym_cnt == '0);
        if (last_cycle) begin
          s_ready = 1'b1;
          if (s_valid) load = 1'b1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The shift register has zeros shifted in, so the final wrap leaves sym_idx at 0 for idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sym_cnt  <= '0;
      sym_left <= '0;
      shreg    <= '0;
      sym_idx  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sym_idx  <= load_sym;
        shreg    <= load_rest;
        sym_cnt  <= '0;
        sym_left <= SL_W'(NSYM);
      end else if (state_q == SEND) begin
        if (sym_wrap) begin
          sym_cnt  <= '0;
          sym_left <= sym_left - 1'b1;
          sym_idx  <= next_sym;
          shreg    <= next_rest;
        end else begin
          sym_cnt <= sym_cnt + 1'b1;
        end
      end
    end
  end

  // Counter and output are never cleared at symbol edges; >= lets a shorter limit take over cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_cnt <= '0;
      fsk_out  <= 1'b0;
    end else if (!tone_active) begin
      tone_cnt <= '0;
      fsk_out  <= 1'b0;
    end else if (tone_cnt >= limit_tab[sym_idx]) begin
      tone_cnt <= '0;
      fsk_out  <= ~fsk_out;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mfsk_modulator.sv
// Scoreboard bench for mfsk_modulator: three parameterisations, one selected at a time,
// with symbol/ready/busy/half-period expectations queued by stimulus and popped by a monitor.
module tb_mfsk_modulator;

  typedef struct {
    logic [1:0] idx;
    int         cyc;
  } sym_exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] v;
  logic [7:0] s_data;
  logic [2:0] rdy_v, fsk_v, st_v, busy_v;
  logic [1:0] idx_v [3];
  logic [1:0] sel;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         c;

  sym_exp_t sym_q[$];
  int       gap_q[$];
  int       ready_q[$];
  int       fall_q[$];

  logic       mb, mf, mact, last_f;
  bit         synced, was_act, was_b;
  int         run;
  logic [1:0] prev_sel;
  sym_exp_t   me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mfsk_modulator #(.DATA_W(8), .BITS_PER_SYM(2), .SYM_CYCLES(400), .BASE_LIMIT(99),
                   .STEP_LIMIT(25), .CNT_W(10), .MSB_FIRST(1), .IDLE_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .s_valid(v[0]), .s_ready(rdy_v[0]), .s_data(s_data),
    .fsk_out(fsk_v[0]), .sym_idx(idx_v[0]), .sym_start(st_v[0]), .busy(busy_v[0]));

  mfsk_modulator #(.DATA_W(8), .BITS_PER_SYM(2), .SYM_CYCLES(360), .BASE_LIMIT(99),
                   .STEP_LIMIT(25), .CNT_W(10), .MSB_FIRST(0), .IDLE_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .s_valid(v[1]), .s_ready(rdy_v[1]), .s_data(s_data),
    .fsk_out(fsk_v[1]), .sym_idx(idx_v[1]), .sym_start(st_v[1]), .busy(busy_v[1]));

  mfsk_modulator #(.DATA_W(8), .BITS_PER_SYM(2), .SYM_CYCLES(400), .BASE_LIMIT(99),
                   .STEP_LIMIT(25), .CNT_W(10), .MSB_FIRST(1), .IDLE_MODE(1)) dut_c (
    .clk(clk), .rst(rst), .s_valid(v[2]), .s_ready(rdy_v[2]), .s_data(s_data),
    .fsk_out(fsk_v[2]), .sym_idx(idx_v[2]), .sym_start(st_v[2]), .busy(busy_v[2]));

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic fail_event(input string name, input int actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event with value %0d, expected none (cycle %0d)", name, actual, cyc);
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic abort(input string name);
    fail_event(name, cyc);
    finish_sim();
  endtask

  task automatic push_gaps(input int g, input int n);
    for (int i = 0; i < n; i++) gap_q.push_back(g);
  endtask

  // Offer one word to the selected DUT and queue the symbols expected from it.
  task automatic apply_stimulus(input logic [7:0] d, input logic [1:0] e0, e1, e2, e3,
                                input int sc, input int n_obs, input bit last,
                                output int hs_cyc);
    int         waited;
    logic [1:0] exp_i [4];
    sym_exp_t   e;
    waited = 0;
    exp_i  = '{e0, e1, e2, e3};
    @(negedge clk);
    s_data = d;
    v      = 3'b000;
    v[sel] = 1'b1;
    while (!rdy_v[sel] && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 5000) abort("handshake_timeout");
    hs_cyc = cyc;
    for (int k = 0; k < n_obs; k++) begin
      e.idx = exp_i[k];
      e.cyc = hs_cyc + 1 + k * sc;
      sym_q.push_back(e);
    end
    if (n_obs == 4) ready_q.push_back(hs_cyc + 4 * sc);
    if (last && n_obs == 4) fall_q.push_back(hs_cyc + 1 + 4 * sc);
    @(posedge clk);
    #1;
    if (last) v = 3'b000;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy_v[sel] && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) abort("busy_timeout");
    repeat (5) @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the selected DUT shows a symbol, ready, busy fall or tone edge.
  initial begin
    prev_sel = 2'd3;
    was_act  = 0;
    was_b    = 0;
    synced   = 0;
    run      = 0;
    last_f   = 1'b0;
    forever begin
      @(negedge clk);
      if (sel != 2'd3) begin
        if (sel != prev_sel) begin
          was_act = 0;
          was_b   = 0;
        end
        mb   = busy_v[sel];
        mf   = fsk_v[sel];
        mact = mb || (sel == 2'd2);
        if (st_v[sel]) begin
          if (sym_q.size() == 0) fail_event("sym_start_unexpected", int'(idx_v[sel]));
          else begin
            me = sym_q.pop_front();
            check_output("sym_idx", int'(idx_v[sel]), int'(me.idx));
            check_output("sym_start_cycle", cyc, me.cyc);
          end
        end
        if (mb && rdy_v[sel]) begin
          if (ready_q.size() == 0) fail_event("s_ready_unexpected", cyc);
          else check_output("s_ready_cycle", cyc, ready_q.pop_front());
        end
        if (was_b && !mb) begin
          if (fall_q.size() == 0) fail_event("busy_fall_unexpected", cyc);
          else check_output("busy_fall_cycle", cyc, fall_q.pop_front());
        end
        if (mact && !was_act) begin
          synced = mb;
          run    = 1;
          last_f = mf;
        end else if (mact) begin
          if (mf != last_f) begin
            if (synced) begin
              if (gap_q.size() == 0) fail_event("tone_edge_unexpected", run);
              else check_output("half_period", run, gap_q.pop_front());
            end
            synced = 1;
            run    = 1;
            last_f = mf;
          end else begin
            run++;
          end
        end
        was_act = mact;
        was_b   = mb;
      end else begin
        was_act = 0;
        was_b   = 0;
      end
      prev_sel = sel;
    end
  end

  initial begin
    int guard;
    rst    = 1'b1;
    v      = 3'b000;
    s_data = 8'h00;
    sel    = 2'd3;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check_output("reset_state", int'({fsk_v[i], busy_v[i], st_v[i], rdy_v[i], idx_v[i]}), 6'b000100);
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_output("idle_outputs", int'({fsk_v[0], rdy_v[0], busy_v[0], st_v[0]}), 4'b0100);
    end

    // Single word, MSB first: tones 0,1,2,3 with carried-over counter at each boundary.
    @(posedge clk);
    #1 sel = 2'd0;
    push_gaps(100, 4); push_gaps(75, 5); push_gaps(50, 8); push_gaps(26, 1); push_gaps(25, 15);
    apply_stimulus(8'h1B, 2'd0, 2'd1, 2'd2, 2'd3, 400, 4, 1'b1, c);
    wait_idle();

    // Back-to-back words with valid held.
    push_gaps(25, 64); push_gaps(100, 15);
    apply_stimulus(8'hFF, 2'd3, 2'd3, 2'd3, 2'd3, 400, 4, 1'b0, c);
    apply_stimulus(8'h00, 2'd0, 2'd0, 2'd0, 2'd0, 400, 4, 1'b1, c);
    wait_idle();

    // Reset at cycle 700 of a word: only the first two symbols ever appear.
    push_gaps(25, 16); push_gaps(50, 6);
    apply_stimulus(8'hE4, 2'd3, 2'd2, 2'd1, 2'd0, 400, 2, 1'b1, c);
    fall_q.push_back(c + 702);
    guard = 0;
    while (cyc != c + 701 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) abort("reset_point_timeout");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("after_reset", int'({fsk_v[0], busy_v[0], rdy_v[0], st_v[0]}), 4'b0010);
    check_output("after_reset_sym_idx", int'(idx_v[0]), 0);
    repeat (900) @(negedge clk);

    // LSB-first instance with 360-cycle symbols.
    @(posedge clk);
    #1 sel = 2'd1;
    push_gaps(25, 14); push_gaps(50, 7); push_gaps(75, 5); push_gaps(100, 3);
    apply_stimulus(8'h1B, 2'd3, 2'd2, 2'd1, 2'd0, 360, 4, 1'b1, c);
    wait_idle();

    // Symbol 0 -> 3 with the tone counter at 60: 61-cycle level, then 25-cycle half-periods.
    push_gaps(100, 3); push_gaps(61, 1); push_gaps(25, 14); push_gaps(100, 7);
    apply_stimulus(8'h0C, 2'd0, 2'd3, 2'd0, 2'd0, 360, 4, 1'b1, c);
    wait_idle();

    check_output("sym_q_leftover", sym_q.size(), 0);
    check_output("gap_q_leftover", gap_q.size(), 0);
    check_output("ready_q_leftover", ready_q.size(), 0);
    check_output("fall_q_leftover", fall_q.size(), 0);
    sym_q.delete(); gap_q.delete(); ready_q.delete(); fall_q.delete();

    // Idle tone instance: symbol-0 tone free-runs.
    @(posedge clk);
    #1 sel = 2'd2;
    push_gaps(100, 5);
    guard = 0;
    while (gap_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check_output("idle_tone_remaining", gap_q.size(), 0);
    check_output("idle_tone_state", int'({busy_v[2], rdy_v[2], idx_v[2]}), 4'b0100);
    gap_q.delete();
    @(posedge clk);
    #1 sel = 2'd3;
    repeat (3) @(negedge clk);
    finish_sim();
  end

endmodule
